// File: rtl/datapath_pkg.sv
// Shared datapath types for the fetch front end.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    localparam word_t PC_RESET = 32'h0000_0000;

    // Sequential fetch address; wraps naturally at the top of the 32-bit space.
    function automatic word_t next_fetch_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of fetched {instr, pc} entries with synchronous flush.
// Latency: a push in cycle n is visible at the head in cycle n+1; the head is read straight from storage.
// Backpressure: pushes while full and pops while empty are ignored; flush discards any same-cycle push or pop.
module fetch_fifo
    import datapath_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int PW = $clog2(BUF_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_dat,
    output logic         head_vld,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_entry_t    mem [BUF_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full     = (cnt == DEPTH_C);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    // A flush wins over everything else in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && head_vld && !flush;

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap on their own.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns fetch_pc, requests imem one word at a time, buffers words for decode.
// Latency: imem hit in cycle n -> instr_valid in cycle n+1; redirect/halt take effect at the next edge.
// Backpressure: decode stalls via instr_ready; requests stop while the buffer is full, the request address holds until a hit.
module instr_fetch_unit
    import datapath_pkg::*;
#(
    parameter word_t RESET_PC  = PC_RESET,
    parameter int    BUF_DEPTH = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  imem_ren,
    output word_t imem_addr,
    input  logic  imem_hit,
    input  word_t imem_load,
    output word_t instr,
    output word_t instr_pc,
    output logic  instr_valid,
    input  logic  instr_ready,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  halted
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    word_t         fetch_pc;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    fetch_entry_t  fifo_push_dat;
    fetch_entry_t  fifo_head;
    logic          in_fetch;
    logic          unused_redirect_bits;

    // Low address bits of a redirect target are ignored by design.
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign in_fetch = (state_q == FETCH);

    // State register: HALTED is sticky until reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt from decode is the only way out of FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Outputs: a request goes out only with buffer room and no redirect/halt this cycle; held low during reset.
    always_comb begin
        imem_ren = 1'b0;
        halted   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_ren = nRST && (fifo_count < DEPTH_C) && !redirect && !halt;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                imem_ren = 1'b0;
                halted   = 1'b0;
            end
        endcase
    end

    assign imem_addr = fetch_pc;

    // Fetch PC: halt freezes it and beats redirect; redirect beats a same-cycle hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_pc <= RESET_PC;
        end else if (in_fetch && !halt) begin
            if (redirect) begin
                fetch_pc <= align_word(redirect_pc);
            end else if (imem_ren && imem_hit) begin
                fetch_pc <= next_fetch_pc(fetch_pc);
            end
        end
    end

    // imem_ren is already low on redirect/halt, so a hit in that cycle never reaches the buffer.
    assign fifo_push     = imem_ren && imem_hit;
    assign fifo_push_dat = '{instr: imem_load, pc: fetch_pc};
    assign fifo_pop      = instr_valid && instr_ready;
    assign fifo_flush    = in_fetch && (halt || redirect);

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head_dat (fifo_head),
        .head_vld (instr_valid),
        .count    (fifo_count)
    );

    assign instr    = fifo_head.instr;
    assign instr_pc = fifo_head.pc;

endmodule
